score_led_unit: RTL and testbench

SCORE_LED_UNIT -- requirements
Module: score_led_unit

---
 rtl/score_led_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_score_led_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_led_unit.sv
// Score/LED unit: marker position, round arbitration, speed-round counting and playfield LEDs.
// Optional speed-round counters enabled by defining SCORE_SPEED_ROUND_EN.
module score_led_unit #(
  parameter int unsigned SPEED_TARGET  = 8,
  parameter int unsigned DISPLAY_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slowen,
  input  logic       pbl,
  input  logic       pbr,
  input  logic       leds_on,
  input  logic       clear,
  input  logic       fake,
  input  logic       speed_round,
  input  logic [2:0] led_control,
  output logic       winrnd,
  output logic       winspeed,
  output logic       speed_exit,
  output logic [8:0] leds,
  output logic       match_over
);

  localparam logic [2:0] LcDark  = 3'b000;
  localparam logic [2:0] LcReset = 3'b001;
  localparam logic [2:0] LcAll   = 3'b010;
  localparam logic [2:0] LcScore = 3'b011;
  localparam logic [2:0] LcFake  = 3'b100;
  localparam logic [2:0] LcSpeed = 3'b110;

  localparam logic [3:0] PosMin = 4'd0;
  localparam logic [3:0] PosMax = 4'd8;
  localparam logic [3:0] PosMid = 4'd4;

`ifdef SCORE_SPEED_ROUND_EN
  localparam int unsigned ExitTicks = DISPLAY_TICKS;
  localparam logic [3:0]  SpeedTgt  = 4'(SPEED_TARGET);
`else
  localparam int unsigned ExitTicks = 1;
`endif
  localparam int unsigned    TickW    = (ExitTicks < 2) ? 1 : $clog2(ExitTicks);
  localparam logic [TickW-1:0] TickLast = TickW'(ExitTicks - 1);

  if (SPEED_TARGET < 1 || SPEED_TARGET > 15) begin : g_bad_target
    $error("SPEED_TARGET must lie in 1..15");
  end
  if (DISPLAY_TICKS < 1) begin : g_bad_ticks
    $error("DISPLAY_TICKS must be at least 1");
  end

  typedef enum logic [1:0] {WinNone, WinLeft, WinRight, WinTie} win_e;

  logic [3:0]       pos_q, pos_d;
  logic             match_over_q, match_over_d;
  logic             armed_q, armed_d;
  logic             used_q, used_d;
  logic             sr_prev_q;
  win_e             win_q, win_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic             exit_done_q, exit_done_d;
  logic             winrnd_q, winrnd_d;
  logic             winspeed_q, winspeed_d;
  logic             speed_exit_q, speed_exit_d;
  logic [8:0]       leds_q, leds_d;

  logic sr_rise, live, foul, round_evt, round_left, round_right;
  logic speed_left, speed_right;

`ifdef SCORE_SPEED_ROUND_EN
  logic [3:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic       sp_done_q, sp_done_d;
  logic       hit_l, hit_r;
`endif

  always_comb begin
    sr_rise = speed_round & ~sr_prev_q;

    // Armed tracks clear directly; used_q limits each round to a single scored event.
    live        = armed_q & ~used_q & ~clear & ~speed_round;
    foul        = fake | (led_control == LcDark);
    round_evt   = live & (pbl ^ pbr) & (foul | (led_control == LcScore));
    round_left  = round_evt & (foul ? pbr : pbl);
    round_right = round_evt & ~round_left;
    armed_d     = ~clear;
    used_d      = clear ? 1'b0 : (used_q | round_evt);
    winrnd_d    = round_evt;

`ifdef SCORE_SPEED_ROUND_EN
    cnt_l_d     = sr_rise ? 4'd0 : cnt_l_q;
    cnt_r_d     = sr_rise ? 4'd0 : cnt_r_q;
    sp_done_d   = sr_rise ? 1'b0 : sp_done_q;
    win_d       = sr_rise ? WinNone : win_q;
    hit_l       = 1'b0;
    hit_r       = 1'b0;
    speed_left  = 1'b0;
    speed_right = 1'b0;
    winspeed_d  = 1'b0;
    // Counters never exceed the target: reaching it freezes the round.
    if (speed_round && !sp_done_d) begin
      if (pbl) cnt_l_d = cnt_l_d + 4'd1;
      if (pbr) cnt_r_d = cnt_r_d + 4'd1;
      hit_l = (cnt_l_d == SpeedTgt);
      hit_r = (cnt_r_d == SpeedTgt);
      if (hit_l || hit_r) begin
        sp_done_d  = 1'b1;
        winspeed_d = 1'b1;
        if (hit_l && hit_r) begin
          win_d = WinTie;
        end else if (hit_l) begin
          win_d      = WinLeft;
          speed_left = 1'b1;
        end else begin
          win_d       = WinRight;
          speed_right = 1'b1;
        end
      end
    end
`else
    speed_left  = 1'b0;
    speed_right = 1'b0;
    winspeed_d  = sr_rise;
    win_d       = sr_rise ? WinTie : win_q;
`endif

    pos_d = pos_q;
    if (!match_over_q) begin
      if ((round_left || speed_left) && pos_q != PosMin) begin
        pos_d = pos_q - 4'd1;
      end else if ((round_right || speed_right) && pos_q != PosMax) begin
        pos_d = pos_q + 4'd1;
      end
    end
    match_over_d = match_over_q | (pos_d == PosMin) | (pos_d == PosMax);

    tick_d       = tick_q;
    exit_done_d  = exit_done_q;
    speed_exit_d = 1'b0;
    if (led_control != LcSpeed) begin
      tick_d      = '0;
      exit_done_d = 1'b0;
    end else if (slowen && !exit_done_q) begin
      if (tick_q == TickLast) begin
        speed_exit_d = 1'b1;
        exit_done_d  = 1'b1;
      end else begin
        tick_d = tick_q + TickW'(1);
      end
    end

    // LEDs use next-state values so the display lines up with the event pulses.
    leds_d = '0;
    if (leds_on) begin
      case (led_control)
        LcReset: leds_d = 9'b0_0001_0000;
        LcAll:   leds_d = '1;
        LcScore: leds_d = 9'd1 << pos_d;
        LcFake:  leds_d = 9'd1 << (PosMax - pos_d);
        LcSpeed: begin
          case (win_d)
            WinLeft:  leds_d = 9'b0_0000_1111;
            WinRight: leds_d = 9'b1_1110_0000;
            WinTie:   leds_d = 9'b0_0001_0000;
            default:  leds_d = '0;
          endcase
        end
        default: leds_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q        <= PosMid;
      match_over_q <= 1'b0;
      armed_q      <= 1'b0;
      used_q       <= 1'b0;
      sr_prev_q    <= 1'b0;
      win_q        <= WinNone;
      tick_q       <= '0;
      exit_done_q  <= 1'b0;
      winrnd_q     <= 1'b0;
      winspeed_q   <= 1'b0;
      speed_exit_q <= 1'b0;
      leds_q       <= '0;
    end else begin
      pos_q        <= pos_d;
      match_over_q <= match_over_d;
      armed_q      <= armed_d;
      used_q       <= used_d;
      sr_prev_q    <= speed_round;
      win_q        <= win_d;
      tick_q       <= tick_d;
      exit_done_q  <= exit_done_d;
      winrnd_q     <= winrnd_d;
      winspeed_q   <= winspeed_d;
      speed_exit_q <= speed_exit_d;
      leds_q       <= leds_d;
    end
  end

`ifdef SCORE_SPEED_ROUND_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_l_q   <= 4'd0;
      cnt_r_q   <= 4'd0;
      sp_done_q <= 1'b0;
    end else begin
      cnt_l_q   <= cnt_l_d;
      cnt_r_q   <= cnt_r_d;
      sp_done_q <= sp_done_d;
    end
  end
`endif

  assign winrnd     = winrnd_q;
  assign winspeed   = winspeed_q;
  assign speed_exit = speed_exit_q;
  assign leds       = leds_q;
  assign match_over = match_over_q;

endmodule

// File: tb/tb_score_led_unit.sv
// Scoreboard bench for score_led_unit: stimulus pushes expected pulses, a monitor pops and checks.
module tb_score_led_unit;

  localparam int Target = 8;
`ifdef SCORE_SPEED_ROUND_EN
  localparam int ExitN = 4;
`else
  localparam int ExitN = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, slowen, pbl, pbr, leds_on, clear, fake, speed_round;
  logic [2:0] led_control;
  logic       winrnd, winspeed, speed_exit, match_over;
  logic [8:0] leds;

  score_led_unit #(.SPEED_TARGET(8), .DISPLAY_TICKS(4)) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .pbl(pbl), .pbr(pbr),
    .leds_on(leds_on), .clear(clear), .fake(fake), .speed_round(speed_round),
    .led_control(led_control), .winrnd(winrnd), .winspeed(winspeed),
    .speed_exit(speed_exit), .leds(leds), .match_over(match_over)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  kind;  // {winrnd, winspeed, speed_exit}
    logic [8:0]  leds;
    logic        mo;
    int unsigned due;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // Reference model state
  int   mpos;
  bit   mmo, mused;
  int   mwin;      // 0 none, 1 left, 2 right, 3 tie
  int   mcl, mcr;
  bit   msdone;
  logic [2:0] m_lc;
  bit   m_lon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [8:0] led_map(input bit on, input logic [2:0] lc, input int p,
                                         input int w);
    logic [8:0] v;
    v = '0;
    if (on) begin
      case (lc)
        3'b001: v = 9'b000010000;
        3'b010: v = 9'h1ff;
        3'b011: v = 9'd1 << p;
        3'b100: v = 9'd1 << (8 - p);
        3'b110: v = (w == 1) ? 9'b000001111 : (w == 2) ? 9'b111100000 :
                    (w == 3) ? 9'b000010000 : 9'b0;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (winrnd || winspeed || speed_exit) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got %b expected none (cycle %0d)",
                 {winrnd, winspeed, speed_exit}, cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("pulse_kind", {29'd0, winrnd, winspeed, speed_exit}, {29'd0, mon_e.kind});
        check("pulse_cycle", cyc, mon_e.due);
        check("pulse_leds", {23'd0, leds}, {23'd0, mon_e.leds});
        check("pulse_match_over", {31'd0, match_over}, {31'd0, mon_e.mo});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] kind);
    exp_t e;
    e.kind = kind;
    e.leds = led_map(m_lon, m_lc, mpos, mwin);
    e.mo   = mmo;
    e.due  = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic set_mode(input logic [2:0] lc, input bit fk, input bit on);
    led_control = lc;
    fake        = fk;
    leds_on     = on;
    m_lc        = lc;
    m_lon       = on;
  endtask

  task automatic do_reset();
    rst = 1'b1; slowen = 0; pbl = 0; pbr = 0; clear = 0; speed_round = 0;
    set_mode(3'b000, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    mpos = 4; mmo = 0; mused = 0; mwin = 0; mcl = 0; mcr = 0; msdone = 0;
    step();
  endtask

  task automatic new_round(input int mode, input bit on);
    case (mode)
      0:       set_mode(3'b011, 1'b0, on);
      1:       set_mode(3'b000, 1'b0, on);
      default: set_mode(3'b100, 1'b1, on);
    endcase
    clear = 1'b1;
    step();
    clear = 1'b0;
    mused = 0;
    step();
  endtask

  task automatic move(input int dir);
    if (!mmo) begin
      mpos = mpos + dir;
      if (mpos < 0) mpos = 0;
      if (mpos > 8) mpos = 8;
    end
    if (mpos == 0 || mpos == 8) mmo = 1;
  endtask

  // Play: step toward presser. Dark or fake: foul steps toward the opponent.
  task automatic round_press(input bit l, input bit r);
    if ((l ^ r) && !mused && !speed_round) begin
      if (m_lc == 3'b011 && !fake) move(l ? -1 : 1);
      else move(l ? 1 : -1);
      mused = 1;
      push(3'b100);
    end
    pbl = l; pbr = r;
    step();
    pbl = 0; pbr = 0;
  endtask

  task automatic speed_start();
    speed_round = 1'b0;
    step();
    speed_round = 1'b1;
`ifdef SCORE_SPEED_ROUND_EN
    mcl = 0; mcr = 0; msdone = 0; mwin = 0;
`else
    mwin = 3;
    push(3'b010);
`endif
    step();
  endtask

  task automatic speed_press(input bit l, input bit r);
`ifdef SCORE_SPEED_ROUND_EN
    if (!msdone) begin
      mcl = (mcl + int'(l) > Target) ? Target : mcl + int'(l);
      mcr = (mcr + int'(r) > Target) ? Target : mcr + int'(r);
      if (mcl == Target || mcr == Target) begin
        msdone = 1;
        if (mcl == Target && mcr == Target) mwin = 3;
        else if (mcl == Target) begin mwin = 1; move(-1); end
        else begin mwin = 2; move(1); end
        push(3'b010);
      end
    end
`endif
    pbl = l; pbr = r;
    step();
    pbl = 0; pbr = 0;
  endtask

  task automatic show_speed(input logic [8:0] req);
    set_mode(3'b110, 1'b0, 1'b1);
    step();
    step();
    @(negedge clk);
    check("speed_display", {23'd0, leds}, {23'd0, req});
    step();
    for (int i = 1; i <= ExitN + 3; i++) begin
      slowen = 1'b1;
      if (i == ExitN) push(3'b001);
      step();
      slowen = 1'b0;
      step();
    end
    set_mode(3'b011, 1'b0, 1'b1);
    step();
    step();
  endtask

  task automatic drained(input string name);
    step();
    step();
    check(name, sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, mode;
    bit on;

    do_reset();
    @(negedge clk);
    check("reset_leds", {23'd0, leds}, 32'd0);
    check("reset_winrnd", {31'd0, winrnd}, 32'd0);
    check("reset_winspeed", {31'd0, winspeed}, 32'd0);
    check("reset_speed_exit", {31'd0, speed_exit}, 32'd0);
    check("reset_match_over", {31'd0, match_over}, 32'd0);
    step();

    // Right press in play from centre
    new_round(0, 1'b1);
    round_press(1'b0, 1'b1);
    drained("play_right");

    // Dark foul, then a second press in the same round is ignored
    new_round(1, 1'b1);
    round_press(1'b1, 1'b0);
    round_press(1'b1, 1'b0);
    drained("dark_foul");

    // Simultaneous press is ignored, following single press scores
    new_round(0, 1'b1);
    round_press(1'b1, 1'b1);
    round_press(1'b1, 1'b0);
    drained("both_then_left");

    // Four right wins from centre end the match; the fifth still pulses
    do_reset();
    for (int i = 0; i < 5; i++) begin
      new_round(0, 1'b1);
      round_press(1'b0, 1'b1);
    end
    @(negedge clk);
    check("match_over_level", {31'd0, match_over}, 32'd1);
    check("match_over_leds", {23'd0, leds}, 32'h100);
    drained("match_end");

    // Randomised rounds
    for (int i = 0; i < 48; i++) begin
      if (i % 16 == 0) do_reset();
      mode = $urandom_range(0, 2);
      on   = ($urandom_range(0, 7) != 0);
      new_round(mode, on);
      sel = $urandom_range(0, 3);
      case (sel)
        0: round_press(1'b1, 1'b0);
        1: round_press(1'b0, 1'b1);
        2: begin
          round_press(1'b1, 1'b1);
          if ($urandom_range(0, 1) == 1) round_press(1'b1, 1'b0);
          else round_press(1'b0, 1'b1);
        end
        default: begin
          round_press($urandom_range(0, 1) == 1, 1'b0);
          round_press(1'b0, 1'b1);
        end
      endcase
    end
    drained("random_rounds");

    // Speed round: left reaches target first (8 left, 7 right)
    do_reset();
    set_mode(3'b011, 1'b0, 1'b1);
    step();
    speed_start();
    for (int i = 0; i < 7; i++) speed_press(1'b1, 1'b1);
    speed_press(1'b1, 1'b0);
    drained("speed_left");
    show_speed(led_map(1'b1, 3'b110, mpos, mwin));
    speed_round = 1'b0;
    drained("speed_display_exit");

    // Speed round tie
    speed_start();
    for (int i = 0; i < Target; i++) speed_press(1'b1, 1'b1);
    drained("speed_tie");
    show_speed(led_map(1'b1, 3'b110, mpos, mwin));
    speed_round = 1'b0;

    // Randomised speed rounds
    for (int k = 0; k < 3; k++) begin
      speed_start();
      for (int i = 0; i < 30; i++) speed_press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      speed_round = 1'b0;
      drained("speed_random");
    end

    // Reset in the same cycle as a scoring press: no pulse afterwards
    new_round(0, 1'b1);
    rst = 1'b1;
    pbr = 1'b1;
    step();
    rst = 1'b0;
    pbr = 1'b0;
    @(negedge clk);
    check("mid_reset_leds", {23'd0, leds}, 32'd0);
    check("mid_reset_match_over", {31'd0, match_over}, 32'd0);
    mpos = 4; mmo = 0; mused = 0; mwin = 0;
    drained("mid_reset_quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
